// File: rtl/arbiter8.sv
`default_nettype none
// ============================================================================
//  Module   : arbiter8
//  Brief    : 8-requester arbiter with registered one-hot grant, grant hold,
//             bounded hold with preemption. Define ARBITER8_ROUND_ROBIN_EN
//             for rotating (round-robin) selection instead of fixed priority.
//  Revision : 1.0  initial release
// ============================================================================
module arbiter8 #(
   parameter int MAX_HOLD = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] req,
   output logic [7:0] grant,
   output logic [2:0] grant_id,
   output logic       grant_valid
);

   localparam int                 c_CNT_W = $clog2(MAX_HOLD + 1);
   localparam logic [c_CNT_W-1:0] c_MAX   = c_CNT_W'(MAX_HOLD);
   localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   state_t             r_state;
   logic [c_CNT_W-1:0] r_cnt;
   logic [7:0]         r_grant;
   logic [2:0]         r_grant_id;
   logic               r_grant_valid;

   logic [7:0]         w_masked;
   logic [2:0]         w_pick_req;
   logic [2:0]         w_pick_masked;
   logic               w_owner_req;
   logic               w_preempt;

`ifdef ARBITER8_ROUND_ROBIN_EN
   logic [2:0] r_ptr;

   // Search order is p-1, p-2, ... wrapping, ending at p; later iterations
   // overwrite earlier ones, so walk the order backwards.
   function automatic logic [2:0] f_pick(input logic [7:0] c, input logic [2:0] p);
      logic [2:0] idx;
      f_pick = 3'd0;
      for (int k = 8; k >= 1; k--) begin
         idx = p - 3'(k);
         if (c[idx]) f_pick = idx;
      end
   endfunction

   assign w_pick_req    = f_pick(req, r_ptr);
   assign w_pick_masked = f_pick(w_masked, r_ptr);
`else
   function automatic logic [2:0] f_pick(input logic [7:0] c);
      f_pick = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (c[i]) f_pick = 3'(i);
      end
   endfunction

   assign w_pick_req    = f_pick(req);
   assign w_pick_masked = f_pick(w_masked);
`endif

   // r_grant is one-hot of the owner, so this removes the owner's request.
   assign w_masked    = req & ~r_grant;
   assign w_owner_req = req[r_grant_id];
   assign w_preempt   = (r_cnt == c_MAX) && (|w_masked);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_cnt         <= '0;
         r_grant       <= 8'd0;
         r_grant_id    <= 3'd0;
         r_grant_valid <= 1'b0;
`ifdef ARBITER8_ROUND_ROBIN_EN
         r_ptr         <= 3'd0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (|req) begin
                  r_state       <= ST_GRANT;
                  r_grant       <= 8'd1 << w_pick_req;
                  r_grant_id    <= w_pick_req;
                  r_grant_valid <= 1'b1;
                  r_cnt         <= c_ONE;
`ifdef ARBITER8_ROUND_ROBIN_EN
                  r_ptr         <= w_pick_req;
`endif
               end
            end
            ST_GRANT: begin
               if (!w_owner_req) begin
                  // Release always leaves one idle cycle before the next owner.
                  r_state       <= ST_IDLE;
                  r_grant       <= 8'd0;
                  r_grant_id    <= 3'd0;
                  r_grant_valid <= 1'b0;
                  r_cnt         <= '0;
               end else if (w_preempt) begin
                  r_grant       <= 8'd1 << w_pick_masked;
                  r_grant_id    <= w_pick_masked;
                  r_cnt         <= c_ONE;
`ifdef ARBITER8_ROUND_ROBIN_EN
                  r_ptr         <= w_pick_masked;
`endif
               end else if (r_cnt != c_MAX) begin
                  r_cnt         <= r_cnt + c_ONE;
               end
            end
         endcase
      end
   end

   assign grant       = r_grant;
   assign grant_id    = r_grant_id;
   assign grant_valid = r_grant_valid;

endmodule
`default_nettype wire

// File: tb/tb_arbiter8.sv
`default_nettype none
// ============================================================================
//  Module   : tb_arbiter8
//  Brief    : Self-checking bench for arbiter8 (table vectors, directed
//             sequences, random traffic against a behavioural model).
//  Revision : 1.0  initial release
// ============================================================================
module tb_arbiter8;

   localparam int MAX_HOLD = 8;

   logic       clk;
   logic       reset;
   logic [7:0] req;
   logic [7:0] grant;
   logic [2:0] grant_id;
   logic       grant_valid;

   int n_checks = 0;
   int n_errors = 0;

   // behavioural model state: owner index (-1 = none), hold count, rr pointer
   int m_owner = -1;
   int m_cnt   = 0;
   int m_ptr   = 0;

   arbiter8 #(.MAX_HOLD(MAX_HOLD)) dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .grant       (grant),
      .grant_id    (grant_id),
      .grant_valid (grant_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic [7:0] req;
      logic [7:0] g;
      logic [2:0] id;
      logic       v;
   } vec_t;

   function automatic int pick(input logic [7:0] c);
`ifdef ARBITER8_ROUND_ROBIN_EN
      for (int k = 1; k <= 8; k++) begin
         int i;
         i = (m_ptr - k + 16) % 8;
         if (c[i]) return i;
      end
`else
      for (int i = 7; i >= 0; i--) begin
         if (c[i]) return i;
      end
`endif
      return -1;
   endfunction

   task automatic model_update(input logic r, input logic [7:0] q);
      logic [7:0] masked;
      int w;
      if (r) begin
         m_owner = -1; m_cnt = 0; m_ptr = 0;
      end else if (m_owner < 0) begin
         if (q != 8'd0) begin
            w = pick(q);
            m_owner = w; m_cnt = 1; m_ptr = w;
         end
      end else if (!q[m_owner]) begin
         m_owner = -1; m_cnt = 0;
      end else begin
         masked = q & ~(8'd1 << m_owner);
         if (m_cnt == MAX_HOLD && masked != 8'd0) begin
            w = pick(masked);
            m_owner = w; m_cnt = 1; m_ptr = w;
         end else if (m_cnt < MAX_HOLD) begin
            m_cnt++;
         end
      end
   endtask

   task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got {grant,id,valid}=%h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock: drive, let the edge happen, advance model, compare on negedge.
   task automatic step(input logic r, input logic [7:0] q);
      logic [7:0] eg;
      logic [2:0] eid;
      reset = r;
      req   = q;
      @(posedge clk);
      model_update(r, q);
      @(negedge clk);
      eg  = (m_owner < 0) ? 8'd0 : (8'd1 << m_owner);
      eid = (m_owner < 0) ? 3'd0 : 3'(m_owner);
      check("model", {grant, grant_id, grant_valid}, {eg, eid, m_owner >= 0});
      n_checks++;
      if (!(grant == 8'd0 || $onehot(grant)) || (grant[grant_id] !== grant_valid)) begin
         n_errors++;
         $display("FAIL invariant: grant=%b id=%0d valid=%b", grant, grant_id, grant_valid);
      end
   endtask

   task automatic expect_id(input string name, input logic [2:0] id);
      check(name, {grant, grant_id, grant_valid}, {8'd1 << id, id, 1'b1});
   endtask

   initial begin
      vec_t tbl[7];
      logic [7:0] r;
      int exp_rr[9];

      reset = 1'b1;
      req   = 8'd0;

      tbl[0] = '{1'b1, 8'hFF, 8'h00, 3'd0, 1'b0};
      tbl[1] = '{1'b0, 8'h01, 8'h01, 3'd0, 1'b1};
      tbl[2] = '{1'b0, 8'h00, 8'h00, 3'd0, 1'b0};
      tbl[3] = '{1'b0, 8'hFF, 8'h80, 3'd7, 1'b1};
      tbl[4] = '{1'b0, 8'h7F, 8'h00, 3'd0, 1'b0};
      tbl[5] = '{1'b0, 8'h7F, 8'h40, 3'd6, 1'b1};
      tbl[6] = '{1'b1, 8'hFF, 8'h00, 3'd0, 1'b0};

      for (int i = 0; i < 7; i++) begin
         step(tbl[i].rst, tbl[i].req);
         check($sformatf("table[%0d]", i), {grant, grant_id, grant_valid},
               {tbl[i].g, tbl[i].id, tbl[i].v});
      end

      // preemption: two requesters held, alternating every MAX_HOLD cycles
      step(1'b1, 8'h00);
      for (int n = 1; n <= 40; n++) begin
         step(1'b0, 8'h81);
         expect_id($sformatf("preempt[%0d]", n), (((n - 1) / MAX_HOLD) % 2 == 0) ? 3'd7 : 3'd0);
      end
      // lone owner keeps the grant indefinitely
      for (int n = 0; n < 20; n++) begin
         step(1'b0, 8'h80);
         expect_id("lone_owner", 3'd7);
      end

      // rotation contrast: owner drops its bit for exactly one edge per grant
`ifdef ARBITER8_ROUND_ROBIN_EN
      exp_rr = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
`else
      exp_rr = '{7, 7, 7, 7, 7, 7, 7, 7, 7};
`endif
      step(1'b1, 8'h00);
      step(1'b0, 8'hFF);
      expect_id("rotate[0]", 3'(exp_rr[0]));
      for (int n = 1; n < 9; n++) begin
         step(1'b0, 8'hFF & ~(8'd1 << grant_id));
         check("rotate_gap", {grant, grant_id, grant_valid}, 12'h000);
         step(1'b0, 8'hFF);
         expect_id($sformatf("rotate[%0d]", n), 3'(exp_rr[n]));
      end

      // reset while requester 3 holds the grant
      step(1'b1, 8'h00);
      step(1'b0, 8'h08);
      step(1'b0, 8'h08);
      expect_id("hold3", 3'd3);
      step(1'b1, 8'hFF);
      check("reset_mid_grant", {grant, grant_id, grant_valid}, 12'h000);
      step(1'b0, 8'hFF);
      expect_id("after_reset", 3'd7);

      // random traffic: requests mostly persist so holds reach MAX_HOLD
      r = 8'd0;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 3) == 0) r = 8'($urandom);
         else if ($urandom_range(0, 7) == 0) r = r ^ (8'd1 << $urandom_range(0, 7));
         step($urandom_range(0, 99) == 0, r);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
